tof_frame_arbiter: RTL

Schedules the 8 ToF I2C readout channels onto the single write port of the shared ToF data BRAM. It grants one sensor at a time using round-robin order, accepts that sensor's zone stream and generates BRAM writes at address {sensor_idx, zone_idx}. It tracks which enabled sensors have delivered a full frame and pulses frame_done to start the downstream sensor-data read FSM.

---
 rtl/tof_frame_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tof_frame_arbiter.sv
// Round-robin arbiter that funnels the ToF zone streams onto the single BRAM write port,
// tracking which enabled sensors have delivered their frame and flagging sticky timeouts.
module tof_frame_arbiter #(
    parameter int N_SENS  = 8,
    parameter int IDX_W   = 3,
    parameter int ZONES   = 64,
    parameter int ZONE_W  = 6,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SENS-1:0]       sens_enable,
    input  logic [N_SENS-1:0]       sens_req,
    output logic [N_SENS-1:0]       grant,
    output logic [IDX_W-1:0]        grant_idx,
    input  logic                    zone_valid,
    input  logic [DATA_W-1:0]       zone_data,
    output logic                    zone_ready,
    output logic                    bram_we,
    output logic [IDX_W+ZONE_W-1:0] bram_addr,
    output logic [DATA_W-1:0]       bram_din,
    output logic                    frame_done,
    output logic [N_SENS-1:0]       done_mask,
    output logic [N_SENS-1:0]       err_mask,
    output logic                    busy
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RELEASE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   last_idx;
    logic [ZONE_W-1:0]  zone_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [N_SENS-1:0]  eligible;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               accept;
    logic               last_word;
    logic               timed_out;
    logic               frame_complete;

    assign eligible       = sens_req & sens_enable & ~done_mask;
    assign accept         = zone_valid && zone_ready;
    assign last_word      = accept && (zone_cnt == ZONE_W'(ZONES - 1));
    assign timed_out      = (state == XFER) && !zone_valid && (to_cnt == TO_W'(TIMEOUT - 1));
    assign frame_complete = (sens_enable != '0) && ((done_mask & sens_enable) == sens_enable);

    // Search starts just after the last granted sensor so every requester gets a turn.
    always_comb begin
        int c;
        pick_found = 1'b0;
        pick_idx   = '0;
        c          = 0;
        for (int i = 1; i <= N_SENS; i++) begin
            c = (int'(last_idx) + i) % N_SENS;
            if (!pick_found && eligible[c]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_found) next_state = XFER;
            XFER:    if (last_word || timed_out) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        zone_ready = (state == XFER);
        busy       = (state == XFER) || (state == RELEASE);
    end

    // The done bit is set on leaving XFER, so the completion test in RELEASE already sees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= '0;
            grant_idx  <= '0;
            last_idx   <= IDX_W'(N_SENS - 1);
            zone_cnt   <= '0;
            to_cnt     <= '0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
            frame_done <= 1'b0;
            done_mask  <= '0;
            err_mask   <= '0;
        end else begin
            bram_we    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant     <= {{(N_SENS-1){1'b0}}, 1'b1} << pick_idx;
                        grant_idx <= pick_idx;
                        last_idx  <= pick_idx;
                        zone_cnt  <= '0;
                        to_cnt    <= '0;
                    end
                end
                XFER: begin
                    if (accept) begin
                        bram_we   <= 1'b1;
                        bram_addr <= {grant_idx, zone_cnt};
                        bram_din  <= zone_data;
                        zone_cnt  <= zone_cnt + 1'b1;
                        to_cnt    <= '0;
                    end else if (timed_out) begin
                        err_mask[grant_idx] <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    if (last_word || timed_out) begin
                        grant                <= '0;
                        done_mask[grant_idx] <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (frame_complete) begin
                        frame_done <= 1'b1;
                        done_mask  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
